// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DP); fetch-first, DP forced after MAX_WAIT waiting cycles.
// Read: gnt T, mem_en T+1, rvalid T+2+RD_LAT; write frees the port at T+2; requests seen while busy get no gnt and must be held.
module mem_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dp_req,
   input  logic              dp_we,
   input  logic [ADDR_W-1:0] dp_addr,
   input  logic [DATA_W-1:0] dp_wdata,
   output logic              dp_gnt,
   output logic              dp_rvalid,
   output logic [DATA_W-1:0] dp_rdata,
   output logic              mem_en,
   output logic              mem_wrt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_nxt;
   logic              own_dp;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [LW-1:0]     lat_cnt;
   logic [WW-1:0]     wait_cnt;

   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      dp_gnt    = 1'b0;
      case (state)
         IDLE: begin
            if (rst) begin
               if (dp_req && (!if_req || wait_cnt == WW'(MAX_WAIT))) begin
                  dp_gnt    = 1'b1;
                  state_nxt = ISSUE;
               end else if (if_req) begin
                  if_gnt    = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE:   state_nxt = lat_we ? IDLE : WAIT;
         WAIT:    if (lat_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         own_dp    <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_cnt   <= '0;
         wait_cnt  <= '0;
         if_rvalid <= 1'b0;
         dp_rvalid <= 1'b0;
         if_rdata  <= '0;
         dp_rdata  <= '0;
      end else begin
         state     <= state_nxt;
         if_rvalid <= 1'b0;
         dp_rvalid <= 1'b0;

         // Starvation count keeps running while a transaction is in flight.
         if (dp_gnt || !dp_req)
            wait_cnt <= '0;
         else if (wait_cnt != WW'(MAX_WAIT))
            wait_cnt <= wait_cnt + WW'(1);

         if (dp_gnt) begin
            own_dp    <= 1'b1;
            lat_we    <= dp_we;
            lat_addr  <= dp_addr;
            lat_wdata <= dp_wdata;
         end else if (if_gnt) begin
            own_dp    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
         end

         if (state == ISSUE)
            lat_cnt <= LW'(RD_LAT - 1);
         else if (state == WAIT && lat_cnt != '0)
            lat_cnt <= lat_cnt - LW'(1);

         if (state == WAIT && lat_cnt == '0) begin
            if (own_dp) begin
               dp_rdata  <= mem_rdata;
               dp_rvalid <= 1'b1;
            end else begin
               if_rdata  <= mem_rdata;
               if_rvalid <= 1'b1;
            end
         end
      end
   end

   assign mem_en    = (state == ISSUE);
   assign mem_wrt   = (state == ISSUE) && lat_we;
   assign mem_addr  = (state == ISSUE) ? lat_addr : '0;
   assign mem_wdata = (state == ISSUE) ? lat_wdata : '0;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// A timeline model (grant cycle plus fixed latency offsets) predicts every output each cycle.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req[2];
   logic [7:0]  if_addr[2];
   logic        if_gnt[2];
   logic        if_rvalid[2];
   logic [15:0] if_rdata[2];
   logic        dp_req[2];
   logic        dp_we[2];
   logic [7:0]  dp_addr[2];
   logic [15:0] dp_wdata[2];
   logic        dp_gnt[2];
   logic        dp_rvalid[2];
   logic [15:0] dp_rdata[2];
   logic        mem_en[2];
   logic        mem_wrt[2];
   logic [7:0]  mem_addr[2];
   logic [15:0] mem_wdata[2];
   logic [15:0] mem_rdata[2];
   logic        busy[2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .MAX_WAIT(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
      .dp_req(dp_req[0]), .dp_we(dp_we[0]), .dp_addr(dp_addr[0]), .dp_wdata(dp_wdata[0]),
      .dp_gnt(dp_gnt[0]), .dp_rvalid(dp_rvalid[0]), .dp_rdata(dp_rdata[0]),
      .mem_en(mem_en[0]), .mem_wrt(mem_wrt[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .MAX_WAIT(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
      .dp_req(dp_req[1]), .dp_we(dp_we[1]), .dp_addr(dp_addr[1]), .dp_wdata(dp_wdata[1]),
      .dp_gnt(dp_gnt[1]), .dp_rvalid(dp_rvalid[1]), .dp_rdata(dp_rdata[1]),
      .mem_en(mem_en[1]), .mem_wrt(mem_wrt[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Model: a transaction is remembered by its grant-relative cycle numbers.
   int          cyc = 0;
   logic        known = 1'b0;
   logic        m_act[2]   = '{1'b0, 1'b0};
   logic        m_dp[2]    = '{1'b0, 1'b0};
   logic        m_we[2]    = '{1'b0, 1'b0};
   logic [7:0]  m_addr[2]  = '{8'h0, 8'h0};
   logic [15:0] m_wdata[2] = '{16'h0, 16'h0};
   logic [15:0] m_ir[2]    = '{16'h0, 16'h0};
   logic [15:0] m_dr[2]    = '{16'h0, 16'h0};
   int          m_tiss[2]  = '{0, 0};
   int          m_tidle[2] = '{0, 0};
   int          m_trv[2]   = '{0, 0};
   int          m_wc[2]    = '{0, 0};

   always @(negedge clk) begin
      logic idle_e, gd_e, gi_e, iss;
      int   lat;
      for (int k = 0; k < 2; k++) begin
         lat    = (k == 0) ? 1 : 3;
         idle_e = !m_act[k] || (cyc >= m_tidle[k]);
         gd_e   = rst && idle_e && dp_req[k] && (!if_req[k] || m_wc[k] == 4);
         gi_e   = rst && idle_e && !gd_e && if_req[k];
         iss    = m_act[k] && (cyc == m_tiss[k]);
         if (known) begin
            chk($sformatf("m%0d_if_gnt", k), if_gnt[k], gi_e);
            chk($sformatf("m%0d_dp_gnt", k), dp_gnt[k], gd_e);
            chk($sformatf("m%0d_busy", k), busy[k], m_act[k] && cyc >= m_tiss[k] && cyc < m_tidle[k]);
            chk($sformatf("m%0d_mem_en", k), mem_en[k], iss);
            chk($sformatf("m%0d_mem_wrt", k), mem_wrt[k], iss && m_we[k]);
            chk($sformatf("m%0d_mem_addr", k), mem_addr[k], iss ? m_addr[k] : 8'h0);
            chk($sformatf("m%0d_mem_wdata", k), mem_wdata[k], iss ? m_wdata[k] : 16'h0);
            chk($sformatf("m%0d_if_rvalid", k), if_rvalid[k],
                m_act[k] && !m_we[k] && !m_dp[k] && cyc == m_trv[k]);
            chk($sformatf("m%0d_dp_rvalid", k), dp_rvalid[k],
                m_act[k] && !m_we[k] && m_dp[k] && cyc == m_trv[k]);
            chk($sformatf("m%0d_if_rdata", k), if_rdata[k], m_ir[k]);
            chk($sformatf("m%0d_dp_rdata", k), dp_rdata[k], m_dr[k]);
         end
         if (!rst) begin
            m_act[k] = 1'b0;
            m_wc[k]  = 0;
            m_ir[k]  = 16'h0;
            m_dr[k]  = 16'h0;
         end else begin
            if (m_act[k] && !m_we[k] && cyc == m_tiss[k] + lat) begin
               if (m_dp[k]) m_dr[k] = mem_rdata[k];
               else         m_ir[k] = mem_rdata[k];
            end
            m_wc[k] = (gd_e || !dp_req[k]) ? 0 : ((m_wc[k] < 4) ? m_wc[k] + 1 : 4);
            if (gd_e || gi_e) begin
               m_act[k]   = 1'b1;
               m_dp[k]    = gd_e;
               m_we[k]    = gd_e && dp_we[k];
               m_addr[k]  = gd_e ? dp_addr[k] : if_addr[k];
               m_wdata[k] = gd_e ? dp_wdata[k] : 16'h0;
               m_tiss[k]  = cyc + 1;
               m_tidle[k] = m_we[k] ? cyc + 2 : cyc + 2 + lat;
               m_trv[k]   = cyc + 2 + lat;
            end
         end
      end
      if (!rst) known = 1'b1;
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at %0t, expected finish long before", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b1;  if_addr[k] = 8'h0;
         dp_req[k] = 1'b1;  dp_we[k] = 1'b0;  dp_addr[k] = 8'h0;  dp_wdata[k] = 16'h0;
         mem_rdata[k] = 16'h0;
      end

      // Reset held with both requests pending.
      for (int r = 0; r < 2; r++) begin
         step; neg;
         for (int k = 0; k < 2; k++) begin
            chk("rst_if_gnt", if_gnt[k], 1'b0);
            chk("rst_dp_gnt", dp_gnt[k], 1'b0);
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_mem_en", mem_en[k], 1'b0);
            chk("rst_rvalid", {if_rvalid[k], dp_rvalid[k]}, 2'b00);
         end
      end
      step;
      rst = 1'b1;
      neg;
      chk("rel_if_gnt0", if_gnt[0], 1'b1);
      chk("rel_dp_gnt0", dp_gnt[0], 1'b0);
      chk("rel_if_gnt1", if_gnt[1], 1'b1);
      step;
      for (int k = 0; k < 2; k++) begin if_req[k] = 1'b0; dp_req[k] = 1'b0; end
      repeat (8) step;

      // IF read, RD_LAT=1.
      mem_rdata[0] = 16'hB123; if_req[0] = 1'b1; if_addr[0] = 8'h10;
      neg; chk("t2_gnt", if_gnt[0], 1'b1);
      step; if_req[0] = 1'b0;
      neg; chk("t2_mem_en", mem_en[0], 1'b1);
      chk("t2_mem_wrt", mem_wrt[0], 1'b0);
      chk("t2_mem_addr", mem_addr[0], 8'h10);
      step; neg; chk("t2_busy_wait", busy[0], 1'b1);
      chk("t2_early_rvalid", if_rvalid[0], 1'b0);
      step; neg; chk("t2_rvalid", if_rvalid[0], 1'b1);
      chk("t2_rdata", if_rdata[0], 16'hB123);
      chk("t2_idle", busy[0], 1'b0);
      step;

      // DP write.
      dp_req[0] = 1'b1; dp_we[0] = 1'b1; dp_addr[0] = 8'h20; dp_wdata[0] = 16'h00FF;
      neg; chk("t3_gnt", dp_gnt[0], 1'b1);
      step; dp_req[0] = 1'b0; dp_we[0] = 1'b0;
      neg; chk("t3_mem_en", mem_en[0], 1'b1);
      chk("t3_mem_wrt", mem_wrt[0], 1'b1);
      chk("t3_mem_addr", mem_addr[0], 8'h20);
      chk("t3_mem_wdata", mem_wdata[0], 16'h00FF);
      step; neg; chk("t3_busy", busy[0], 1'b0);
      chk("t3_rvalid", dp_rvalid[0], 1'b0);
      step; neg; chk("t3_rvalid_late", dp_rvalid[0], 1'b0);
      step;

      // Starvation: both held, DP forced at T+6.
      if_req[0] = 1'b1; if_addr[0] = 8'h40; dp_req[0] = 1'b1; dp_addr[0] = 8'h30;
      for (int c = 0; c < 10; c++) begin
         neg;
         chk($sformatf("t4_if_gnt_c%0d", c), if_gnt[0], (c == 0 || c == 3 || c == 9));
         chk($sformatf("t4_dp_gnt_c%0d", c), dp_gnt[0], (c == 6));
         step;
         if (c == 6) dp_req[0] = 1'b0;
         if (c == 9) if_req[0] = 1'b0;
      end
      repeat (4) step;

      // Reset during the WAIT of an IF read.
      mem_rdata[0] = 16'hDEAD; if_req[0] = 1'b1; if_addr[0] = 8'h50;
      neg; chk("t5_gnt", if_gnt[0], 1'b1);
      step; if_req[0] = 1'b0;
      neg; step; rst = 1'b0;
      neg; chk("t5_busy_wait", busy[0], 1'b1);
      chk("t5_old_rdata", if_rdata[0], 16'hB123);
      step; rst = 1'b1;
      neg; chk("t5_rvalid", if_rvalid[0], 1'b0);
      chk("t5_rdata", if_rdata[0], 16'h0);
      chk("t5_mem_en", mem_en[0], 1'b0);
      chk("t5_busy", busy[0], 1'b0);
      step; neg; chk("t5_rvalid_late", if_rvalid[0], 1'b0);
      step;

      // DP read on the RD_LAT=3 instance; IF requests from T+1 and must wait.
      mem_rdata[1] = 16'h1234; dp_req[1] = 1'b1; dp_we[1] = 1'b0; dp_addr[1] = 8'h05;
      for (int c = 0; c < 6; c++) begin
         neg;
         chk($sformatf("t6_dp_gnt_c%0d", c), dp_gnt[1], (c == 0));
         chk($sformatf("t6_if_gnt_c%0d", c), if_gnt[1], (c == 5));
         chk($sformatf("t6_mem_en_c%0d", c), mem_en[1], (c == 1));
         chk($sformatf("t6_dp_rvalid_c%0d", c), dp_rvalid[1], (c == 5));
         if (c == 1) chk("t6_mem_addr", mem_addr[1], 8'h05);
         if (c == 5) chk("t6_dp_rdata", dp_rdata[1], 16'h1234);
         step;
         if (c == 0) begin dp_req[1] = 1'b0; if_req[1] = 1'b1; end
         if (c == 5) if_req[1] = 1'b0;
      end
      repeat (6) step;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
